// File: rtl/pc_fetch.sv
// Instruction fetch unit: issues one imem read at a time, holds the returned
// word for decode until accepted, and redirects the PC on taken branches.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCsrc,
  input  logic [31:0] ImmOp,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  // state | meaning
  // IDLE  | one cycle after reset release
  // REQ   | imem_req=1, imem_addr=pc
  // WAIT  | request outstanding, waiting for imem_rvalid
  // HOLD  | instruction presented to decode until handshake
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] instr_q, instr_nx;
  logic [31:0] ipc_q, ipc_nx;
  logic        valid_q, valid_nx;
  logic        drop, drop_nx;
  logic [31:0] target;

  assign target = (branch_pc + ImmOp) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      valid_q <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      instr_q <= instr_nx;
      ipc_q   <= ipc_nx;
      valid_q <= valid_nx;
      drop    <= drop_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr_q;
    ipc_nx   = ipc_q;
    valid_nx = valid_q;
    drop_nx  = drop;

    // A response seen outside WAIT can only be the stale one being tracked.
    if (imem_rvalid && (state != WAIT)) drop_nx = 1'b0;

    case (state)
      IDLE: state_nx = REQ;
      REQ:  state_nx = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (drop) begin
            drop_nx = 1'b0;
          end else begin
            instr_nx = imem_rdata;
            ipc_nx   = pc;
            valid_nx = 1'b1;
            pc_nx    = pc + 32'd4;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_nx = 1'b0;
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Redirect overrides everything above; a request left in flight must be dropped later.
    if (PCsrc) begin
      pc_nx    = target;
      state_nx = REQ;
      valid_nx = 1'b0;
      instr_nx = instr_q;
      ipc_nx   = ipc_q;
      case (state)
        REQ:     drop_nx = 1'b1;
        WAIT:    drop_nx = drop | ~imem_rvalid;
        default: ;
      endcase
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr       = valid_q ? instr_q : NOP_INSTR;
  assign instr_pc    = ipc_q;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the value instr holds when no valid instruction is present.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 PCsrc  in  1  SHALL mean branch taken (from control); sampled every cycle.
REQ-006 ImmOp  in  32  SHALL be the sign-extended branch offset.
REQ-007 branch_pc  in  32  SHALL be the PC of the branching instruction.
REQ-008 imem_req  out  1  SHALL be the instruction-memory read request, one cycle wide.
REQ-009 imem_addr  out  32  SHALL be the fetch address, valid while imem_req=1.
REQ-010 imem_rvalid  in  1  SHALL mean imem_rdata is valid this cycle.
REQ-011 imem_rdata  in  32  SHALL be the returned instruction word.
REQ-012 instr_valid  out  1  SHALL mean instr/instr_pc carry a fetched instruction for decode.
REQ-013 instr  out  32  SHALL be the instruction word; opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
REQ-014 instr_pc  out  32  SHALL be the address from which instr was fetched.
REQ-015 instr_ready  in  1  SHALL mean decode accepts instr this cycle; transfer occurs when instr_valid and instr_ready are both 1.

Function
REQ-016 The block SHALL implement FSM states IDLE, REQ, WAIT, HOLD with at most one outstanding memory request.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 REQ SHALL assert imem_req=1 with imem_addr=PC for exactly one cycle, then go to WAIT.
REQ-019 imem_rvalid SHALL be ignored in every state except WAIT.
REQ-020 In WAIT, imem_rvalid=1 SHALL capture imem_rdata into instr, PC into instr_pc, set instr_valid=1, set PC=PC+4 (modulo 2^32), and go to HOLD.
REQ-021 In HOLD, instr/instr_pc/instr_valid SHALL stay stable until the handshake completes; the handshake cycle SHALL go to REQ, and instr_valid SHALL be 0 the following cycle.
REQ-022 Steady-state throughput SHALL be one instruction per 3 cycles given 1-cycle memory latency (REQ, WAIT, HOLD).
REQ-023 When PCsrc=1, the block SHALL set PC=(branch_pc+ImmOp) with bits [1:0] forced to 00, and go to REQ in any state.
REQ-024 Redirect in WAIT SHALL discard the outstanding response, including one arriving in the same cycle, and SHALL not set instr_valid.
REQ-025 Redirect in HOLD SHALL clear instr_valid the next cycle; if instr_ready=1 in the same cycle, the handshake SHALL count as completed.
REQ-026 Redirect in REQ SHALL cancel nothing already issued; the response to that issued request SHALL be discarded.
REQ-027 A redirect SHALL take precedence over PC+4 increment when both occur in the same cycle.
REQ-028 When instr_valid=0, instr SHALL equal NOP_INSTR.
REQ-029 Adders SHALL be 32-bit with carry discarded; ImmOp SHALL be added as two's complement.

Reset
REQ-030 While rst_n=0, the block SHALL immediately (asynchronously) set state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC, drop flag=0.
REQ-031 Reset asserted mid-fetch SHALL abandon the request, and a late imem_rvalid after release SHALL be ignored (state IDLE/REQ).

Verification
REQ-032 Release reset, 1-cycle memory, instr_ready=1 -> imem_req at cycles 2,5,8 with addr 0x0,0x4,0x8; instr_valid pulses carrying instr_pc 0x0,0x4,0x8.
REQ-033 Hold instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, instr_valid=1 throughout, no imem_req until ready.
REQ-034 In WAIT, pulse PCsrc=1 with branch_pc=0x10, ImmOp=0xFFFF_FFF8, same-cycle imem_rvalid -> response dropped, next imem_addr=0x08.
REQ-035 In HOLD, set PCsrc=1 and instr_ready=1 together with branch_pc=0x20, ImmOp=0x0000_0006 -> handshake counted, next imem_addr=0x24 (bits [1:0] cleared).
REQ-036 Set PC=0xFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000.
REQ-037 Assert rst_n=0 during WAIT, then deliver imem_rvalid after release -> outputs at reset values, response ignored, first imem_addr=RESET_PC.
